// File: rtl/layer_sequencer.sv
// layer_sequencer: loads weights/biases into a neuron layer,
// broadcasts one input vector and gathers the neuron outputs.
module layer_sequencer #(
  parameter int layerNo   = 0,
  parameter int numNeuron = 30,
  parameter int numWeight = 784,
  parameter int dataWidth = 16,
  parameter int timeout   = 64,
  localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [31:0]                    cfg_wdata,
  input  logic                           cfg_wvalid,
  output logic                           cfg_wready,
  output logic                           weightValid,
  output logic                           biasValid,
  output logic [31:0]                    weightValue,
  output logic [31:0]                    biasValue,
  output logic [31:0]                    config_layer_num,
  output logic [31:0]                    config_neuron_num,
  input  logic                           run_start,
  output logic                           in_rd_en,
  output logic [AW-1:0]                  in_rd_addr,
  input  logic [dataWidth-1:0]           in_rd_data,
  output logic [dataWidth-1:0]           myinput,
  output logic                           myinputValid,
  input  logic [numNeuron*dataWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]           neuron_outvalid,
  output logic [numNeuron*dataWidth-1:0] result_data,
  output logic                           busy,
  output logic                           cfg_done,
  output logic                           done,
  output logic                           err
);

  localparam int NB = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam int TW = $clog2(timeout + 1);
  localparam logic [AW-1:0] W_LAST  = AW'(numWeight - 1);
  localparam logic [NB-1:0] N_LAST  = NB'(numNeuron - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(timeout - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_B, FETCH, WAIT_OUT
  } state_t;

  state_t state, nxt;

  logic [AW-1:0] w_cnt;
  logic [AW-1:0] rd_cnt;
  logic [NB-1:0] n_cnt;
  logic [TW-1:0] wd_cnt;
  logic [numNeuron-1:0] mask;
  logic [numNeuron-1:0] mask_nxt;
  logic mask_full;
  logic hs;
  logic collect;
  logic go_cfg, go_run, fin_cfg, fin_run, to_hit;

  assign cfg_wready = (state == LOAD_W) || (state == LOAD_B);
  assign hs         = cfg_wvalid && cfg_wready;
  assign in_rd_en   = (state == FETCH);
  assign in_rd_addr = rd_cnt;
  assign busy       = (state != IDLE);
  assign collect    = (state == FETCH) || (state == WAIT_OUT);
  assign mask_nxt   = mask | neuron_outvalid;
  assign mask_full  = &mask_nxt;
  assign config_layer_num = 32'(layerNo);
  // buffer data lands one cycle after the read, aligned with valid
  assign myinput    = myinputValid ? in_rd_data : '0;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next-state and phase events
  always_comb begin
    nxt     = state;
    go_cfg  = 1'b0;
    go_run  = 1'b0;
    fin_cfg = 1'b0;
    fin_run = 1'b0;
    to_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          nxt    = LOAD_W;
          go_cfg = 1'b1;
        end else if (run_start) begin
          nxt    = FETCH;
          go_run = 1'b1;
        end
      end
      LOAD_W: begin
        if (hs && w_cnt == W_LAST) nxt = LOAD_B;
      end
      LOAD_B: begin
        if (hs) begin
          if (n_cnt == N_LAST) begin
            nxt     = IDLE;
            fin_cfg = 1'b1;
          end else begin
            nxt = LOAD_W;
          end
        end
      end
      FETCH: begin
        if (rd_cnt == W_LAST) begin
          if (mask_full) begin
            nxt     = IDLE;
            fin_run = 1'b1;
          end else begin
            nxt = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (mask_full) begin
          nxt     = IDLE;
          fin_run = 1'b1;
        end else if (wd_cnt == TO_LAST) begin
          nxt     = IDLE;
          fin_run = 1'b1;
          to_hit  = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // weight, neuron, read and watchdog counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cnt  <= '0;
      n_cnt  <= '0;
      rd_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      if (go_cfg) begin
        w_cnt <= '0;
        n_cnt <= '0;
      end else if (hs && state == LOAD_W) begin
        w_cnt <= w_cnt + 1'b1;
      end else if (hs && state == LOAD_B) begin
        w_cnt <= '0;
        if (n_cnt != N_LAST) n_cnt <= n_cnt + 1'b1;
      end
      if (go_run)               rd_cnt <= '0;
      else if (state == FETCH)  rd_cnt <= rd_cnt + 1'b1;
      if (state == WAIT_OUT)    wd_cnt <= wd_cnt + 1'b1;
      else                      wd_cnt <= '0;
    end
  end

  // neuron load strobes, one cycle after each handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_neuron_num <= '0;
      cfg_done          <= 1'b0;
    end else begin
      weightValid <= hs && (state == LOAD_W);
      biasValid   <= hs && (state == LOAD_B);
      cfg_done    <= fin_cfg;
      if (hs) begin
        config_neuron_num <= 32'(n_cnt);
        if (state == LOAD_W) weightValue <= cfg_wdata;
        else                 biasValue   <= cfg_wdata;
      end
    end
  end

  // input broadcast valid, completion mask, results and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      myinputValid <= 1'b0;
      mask         <= '0;
      result_data  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      myinputValid <= in_rd_en;
      done         <= fin_run;
      if (go_run)      err <= 1'b0;
      else if (to_hit) err <= 1'b1;
      if (go_run)       mask <= '0;
      else if (collect) mask <= mask_nxt;
      for (int n = 0; n < numNeuron; n++) begin
        if (collect && neuron_outvalid[n])
          result_data[n*dataWidth +: dataWidth] <=
            neuron_out[n*dataWidth +: dataWidth];
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer,
// small layer of 3 neurons x 4 weights.
module tb_layer_sequencer;

  localparam int NN = 3;
  localparam int NW = 4;
  localparam int DW = 16;
  localparam int TO = 64;
  localparam int LN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic [31:0] cfg_wdata = '0;
  logic cfg_wvalid = 1'b0;
  logic cfg_wready;
  logic weightValid, biasValid;
  logic [31:0] weightValue, biasValue;
  logic [31:0] config_layer_num, config_neuron_num;
  logic run_start = 1'b0;
  logic in_rd_en;
  logic [1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data = '0;
  logic [DW-1:0] myinput;
  logic myinputValid;
  logic [NN*DW-1:0] neuron_out = '0;
  logic [NN-1:0] neuron_outvalid = '0;
  logic [NN*DW-1:0] result_data;
  logic busy, cfg_done, done, err;

  layer_sequencer #(
    .layerNo(LN), .numNeuron(NN), .numWeight(NW),
    .dataWidth(DW), .timeout(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_wdata(cfg_wdata),
    .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .run_start(run_start), .in_rd_en(in_rd_en),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .myinput(myinput), .myinputValid(myinputValid),
    .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
    .result_data(result_data), .busy(busy),
    .cfg_done(cfg_done), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [NW];
  always @(posedge clk)
    if (in_rd_en) in_rd_data <= mem[in_rd_addr];

  typedef struct {int cyc; logic b; logic [31:0] n; logic [31:0] v;} ld_t;
  typedef struct {int cyc; int v;} ev_t;
  typedef struct {int cyc; logic e; logic [NN*DW-1:0] r;} dn_t;

  ld_t ld_q[$];
  ev_t rd_q[$];
  ev_t mi_q[$];
  ev_t cd_q[$];
  dn_t dn_q[$];

  int vecs = 0;
  int errs = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  ld_t le;
  ev_t ee;
  dn_t de;

  always @(negedge clk) if (rst) begin
    if (weightValid || biasValid) begin
      if (ld_q.size() == 0) chk("ld_unexpected", {weightValid, biasValid}, 0);
      else begin
        le = ld_q.pop_front();
        chk("ld_cyc", cyc, le.cyc);
        chk("ld_kind", {weightValid, biasValid}, le.b ? 2'b01 : 2'b10);
        chk("ld_neuron", config_neuron_num, le.n);
        chk("ld_data", biasValid ? biasValue : weightValue, le.v);
      end
    end
    if (in_rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", in_rd_en, 0);
      else begin
        ee = rd_q.pop_front();
        chk("rd_cyc", cyc, ee.cyc);
        chk("rd_addr", in_rd_addr, ee.v);
      end
    end
    if (myinputValid) begin
      if (mi_q.size() == 0) chk("mi_unexpected", myinputValid, 0);
      else begin
        ee = mi_q.pop_front();
        chk("mi_cyc", cyc, ee.cyc);
        chk("mi_data", myinput, ee.v);
      end
    end
    if (cfg_done) begin
      if (cd_q.size() == 0) chk("cfg_done_unexpected", cfg_done, 0);
      else begin
        ee = cd_q.pop_front();
        chk("cfg_done_cyc", cyc, ee.cyc);
        chk("cfg_done_busy", busy, 0);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        de = dn_q.pop_front();
        chk("done_cyc", cyc, de.cyc);
        chk("done_err", err, de.e);
        chk("done_result", result_data, de.r);
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_wv"}, {weightValid, biasValid}, 0);
    chk({tag, "_vals"}, {weightValue, biasValue}, 0);
    chk({tag, "_nnum"}, config_neuron_num, 0);
    chk({tag, "_lnum"}, config_layer_num, LN);
    chk({tag, "_ctl"}, {cfg_wready, in_rd_en, myinputValid,
                        busy, cfg_done, done, err}, 0);
    chk({tag, "_addr_in"}, {in_rd_addr, myinput}, 0);
    chk({tag, "_result"}, result_data, 0);
  endtask

  task automatic do_load(input bit toggle);
    int w;
    int k;
    w = 1;
    k = 0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    while (w <= 15) begin
      chk("wready_load", cfg_wready, 1);
      if (!toggle || (k % 2 == 0)) begin
        cfg_wvalid = 1'b1;
        cfg_wdata  = w;
        ld_q.push_back('{cyc + 1, (w % 5 == 0), (w - 1) / 5, w});
        if (w == 15) cd_q.push_back('{cyc + 1, 0});
        w++;
      end else begin
        cfg_wvalid = 1'b0;
        cfg_wdata  = 32'hdead_beef;
      end
      k++;
      @(negedge clk);
    end
    cfg_wvalid = 1'b0;
    chk("wready_after", cfg_wready, 0);
    @(negedge clk);
  endtask

  task automatic do_run(input int off[NN], input logic [DW-1:0] val[NN],
                        input int len, input logic e_err,
                        input logic [NN*DW-1:0] e_res);
    int t;
    logic [NN-1:0] v;
    logic [NN*DW-1:0] d;
    t = cyc;
    run_start = 1'b1;
    for (int i = 0; i < NW; i++) begin
      rd_q.push_back('{t + 1 + i, i});
      mi_q.push_back('{t + 2 + i, int'(mem[i])});
    end
    dn_q.push_back('{t + 5 + len, e_err, e_res});
    @(negedge clk);
    run_start = 1'b0;
    chk("err_clr", err, 0);
    chk("busy_run", busy, 1);
    repeat (4) @(negedge clk);
    for (int c = 0; c < len; c++) begin
      v = '0;
      d = {NN{16'hbeef}};
      for (int n = 0; n < NN; n++)
        if (off[n] == c) begin
          v[n] = 1'b1;
          d[n*DW +: DW] = val[n];
        end
      neuron_outvalid = v;
      neuron_out = d;
      @(negedge clk);
    end
    neuron_outvalid = '0;
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("err_end", err, e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    do_load(1'b0);
    do_load(1'b1);

    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; mem[3] = 16'd8;
    do_run('{5, 9, 2}, '{16'h0022, 16'h0033, 16'h0011}, 10, 1'b0,
           {16'h0011, 16'h0033, 16'h0022});

    mem[0] = 16'h0a1; mem[1] = 16'h0b2; mem[2] = 16'h0c3; mem[3] = 16'h0d4;
    do_run('{1, -1, 3}, '{16'h0044, 16'h0000, 16'h0055}, TO, 1'b1,
           {16'h0055, 16'h0033, 16'h0044});

    mem[0] = 16'h111; mem[1] = 16'h222; mem[2] = 16'h333; mem[3] = 16'h444;
    do_run('{2, 2, 2}, '{16'h0001, 16'h0002, 16'h0003}, 3, 1'b0,
           {16'h0003, 16'h0002, 16'h0001});

    cfg_start = 1'b1;
    run_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    run_start = 1'b0;
    chk("both_busy", busy, 1);
    chk("both_wready", cfg_wready, 1);
    chk("both_no_fetch", in_rd_en, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, cfg_wready}, 0);

    chk("ld_q_left", ld_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("mi_q_left", mi_q.size(), 0);
    chk("cd_q_left", cd_q.size(), 0);
    chk("dn_q_left", dn_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
